regfile_mp: RTL and testbench



---
 rtl/rv_pkg.sv | 11 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_rd_port.sv | 41 ++++
 rtl/regfile_mp.sv | 82 ++++++++
 tb/tb_regfile_mp.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared rv32i core definitions used by the register file and its read ports.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_AW   = 5;
    localparam int REG_ZERO = 0;

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage : rv_pkg

// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int NISS  = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NISS-1:0]     iss_en;
    logic [NISS*AW-1:0]  iss_rd;
    logic                busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
        output rd_data, rd_busy, busy_any
    );

endinterface : regfile_mp_if

// File: rtl/regfile_rd_port.sv
// One combinational read port: stored value, optional same-cycle write bypass
// (highest-index write port wins) and x0 masking.
module regfile_rd_port
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                rst_n,
    input  logic [AW-1:0]       addr,
    input  logic [XLEN-1:0]     regs [NREGS],
    input  logic [NREGS-1:0]    busy_vec,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     data,
    output logic                busy
);

    // Select stored state, let later write ports override earlier ones, then force x0 to zero.
    always_comb begin
        data = regs[addr];
        busy = busy_vec[addr];
        if (BYPASS != 0 && rst_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == addr) begin
                    data = wr_data[j*XLEN +: XLEN];
                    busy = 1'b0;
                end
            end
        end
        if (int'(addr) == REG_ZERO) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a pending-write scoreboard.
// Owns storage, busy bits and reset; read ports are generated sub-modules.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int NISS   = 1,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] next_busy;

    // Scoreboard next state: completions clear, issues set afterwards so a new producer wins.
    always_comb begin
        next_busy = busy;
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j]) begin
                next_busy[bus.wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        for (int i = 0; i < NISS; i++) begin
            if (bus.iss_en[i]) begin
                next_busy[bus.iss_rd[i*AW +: AW]] = 1'b1;
            end
        end
        next_busy[0] = 1'b0;
    end

    // Storage and busy bits; later write ports overwrite earlier ones on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0) begin
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                end
            end
            busy <= next_busy;
        end
    end

    // Drain detection looks only at stored busy bits.
    always_comb begin
        bus.busy_any = |busy;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .NWR    (NWR),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd_port (
            .rst_n    (rst_n),
            .addr     (bus.rd_addr[k*AW +: AW]),
            .regs     (regs),
            .busy_vec (busy),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .data     (bus.rd_data[k*XLEN +: XLEN]),
            .busy     (bus.rd_busy[k])
        );
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// driven with identical stimulus, two read ports and two write ports each.
module tb_regfile_mp;
    import rv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .NISS(1)) bus_b ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .NISS(1)) bus_n ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .NISS(1), .BYPASS(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .NISS(1), .BYPASS(0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n.slave)
    );

    assign bus_n.rd_addr = bus_b.rd_addr;
    assign bus_n.wr_en   = bus_b.wr_en;
    assign bus_n.wr_addr = bus_b.wr_addr;
    assign bus_n.wr_data = bus_b.wr_data;
    assign bus_n.iss_en  = bus_b.iss_en;
    assign bus_n.iss_rd  = bus_b.iss_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input reg_addr_t rd0, input reg_addr_t rd1,
                                 input logic [1:0] wen,
                                 input reg_addr_t wa0, input xword_t wd0,
                                 input reg_addr_t wa1, input xword_t wd1,
                                 input logic ien, input reg_addr_t ird);
        bus_b.rd_addr = {rd1, rd0};
        bus_b.wr_en   = wen;
        bus_b.wr_addr = {wa1, wa0};
        bus_b.wr_data = {wd1, wd0};
        bus_b.iss_en  = ien;
        bus_b.iss_rd  = ird;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("reset_rd_data", bus_b.rd_data[31:0], 32'h0);
        checkOutput("reset_busy_any", {31'b0, bus_b.busy_any}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset mid-operation: committed write and pending issue are discarded.
        applyStimulus(5'd5, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd6);
        checkOutput("bypass_x5", bus_b.rd_data[31:0], 32'hDEADBEEF);
        tick();
        applyStimulus(5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("stored_x5", bus_n.rd_data[31:0], 32'hDEADBEEF);
        checkOutput("busy_any_x6", {31'b0, bus_n.busy_any}, 32'h1);
        applyStimulus(5'd5, 5'd0, 2'b01, 5'd5, 32'h0BADF00D, 5'd0, 32'h0, 1'b0, 5'd0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_x5", bus_n.rd_data[31:0], 32'h0);
        checkOutput("rst_no_bypass", bus_b.rd_data[31:0], 32'h0);
        checkOutput("rst_busy_any", {31'b0, bus_b.busy_any}, 32'h0);
        tick();
        applyStimulus(5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_x5", bus_b.rd_data[31:0], 32'h0);
        checkOutput("post_rst_busy_any", {31'b0, bus_b.busy_any}, 32'h0);

        // x0 stays zero and never busy, even with bypass.
        applyStimulus(5'd0, 5'd0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0);
        checkOutput("x0_bypass_data", bus_b.rd_data[31:0], 32'h0);
        checkOutput("x0_bypass_busy", {31'b0, bus_b.rd_busy[0]}, 32'h0);
        tick();
        applyStimulus(5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x0_stored", bus_n.rd_data[31:0], 32'h0);
        checkOutput("x0_busy_any", {31'b0, bus_n.busy_any}, 32'h0);

        // Same-cycle bypass versus registered-only visibility.
        applyStimulus(5'd7, 5'd0, 2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("bypass_x7", bus_b.rd_data[31:0], 32'h12345678);
        checkOutput("nobypass_x7_old", bus_n.rd_data[31:0], 32'h0);
        tick();
        applyStimulus(5'd7, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("nobypass_x7_new", bus_n.rd_data[31:0], 32'h12345678);
        checkOutput("x7_not_busy", {31'b0, bus_n.busy_any}, 32'h0);

        // Scoreboard: issue x3, complete four cycles later.
        applyStimulus(5'd3, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3);
        checkOutput("x3_busy_c0", {31'b0, bus_b.rd_busy[0]}, 32'h0);
        tick();
        applyStimulus(5'd3, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x3_busy_c1", {31'b0, bus_b.rd_busy[0]}, 32'h1);
        checkOutput("x3_busy_any", {31'b0, bus_n.busy_any}, 32'h1);
        tick();
        tick();
        tick();
        checkOutput("x3_busy_c3", {31'b0, bus_n.rd_busy[0]}, 32'h1);
        applyStimulus(5'd3, 5'd0, 2'b01, 5'd3, 32'h000000A5, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x3_bypass_busy", {31'b0, bus_b.rd_busy[0]}, 32'h0);
        checkOutput("x3_bypass_data", bus_b.rd_data[31:0], 32'h000000A5);
        checkOutput("x3_nobyp_busy", {31'b0, bus_n.rd_busy[0]}, 32'h1);
        tick();
        applyStimulus(5'd3, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x3_stored_busy", {31'b0, bus_n.rd_busy[0]}, 32'h0);
        checkOutput("x3_stored_data", bus_n.rd_data[31:0], 32'h000000A5);
        checkOutput("x3_drained", {31'b0, bus_n.busy_any}, 32'h0);

        // Set beats clear on the same edge.
        applyStimulus(5'd9, 5'd0, 2'b01, 5'd9, 32'h00000001, 5'd0, 32'h0, 1'b1, 5'd9);
        tick();
        applyStimulus(5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x9_data", bus_n.rd_data[31:0], 32'h00000001);
        checkOutput("x9_busy", {31'b0, bus_n.rd_busy[0]}, 32'h1);
        applyStimulus(5'd9, 5'd0, 2'b01, 5'd9, 32'h00000002, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        applyStimulus(5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x9_cleared", {31'b0, bus_n.busy_any}, 32'h0);

        // Write collision: port 1 wins in bypass and storage; second read port on x0.
        applyStimulus(5'd4, 5'd0, 2'b11, 5'd4, 32'h00000011, 5'd4, 32'h00000022, 1'b0, 5'd0);
        checkOutput("coll_bypass", bus_b.rd_data[31:0], 32'h00000022);
        checkOutput("coll_rd1_x0", bus_b.rd_data[63:32], 32'h0);
        checkOutput("coll_rd1_busy", {31'b0, bus_b.rd_busy[1]}, 32'h0);
        tick();
        applyStimulus(5'd4, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("coll_stored_n", bus_n.rd_data[31:0], 32'h00000022);
        checkOutput("coll_stored_b", bus_b.rd_data[31:0], 32'h00000022);
        checkOutput("coll_stored_rd1", bus_n.rd_data[63:32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp
